// File: rtl/mux_nto1_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_nto1_arb_pkg                                             |
// | Description : Shared definitions for the N-to-1 arbitrated selector.       |
// |               MODE_FIXED / MODE_RR encode mode_i.                          |
// |               Optional feature macro: MUX_LAST_EN (define it on the        |
// |               compile line to enable last_i/last_o packet locking).        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mux_nto1_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;  // channel chosen by select_i
  localparam logic MODE_RR    = 1'b1;  // round-robin between valid inputs

endpackage : mux_nto1_arb_pkg
`default_nettype wire

// File: rtl/mux_nto1_arb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Combinational rotate-priority arbiter. Grants the first      |
// |               requesting channel found searching cyclically from ptr+1.    |
// | Ports       : req     [CH]    per-channel request                          |
// |               ptr     [SEL_W] last granted channel                         |
// |               gnt_idx [SEL_W] granted channel (valid when gnt_vld)         |
// |               gnt_vld         at least one request present                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int CH    = 4,
  localparam int SEL_W = $clog2(CH)
) (
  input  logic [CH-1:0]    req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  // Walk from the farthest candidate to the nearest so the last hit (the
  // nearest to ptr+1) is the one that sticks.
  always_comb begin
    int k;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    k       = 0;
    for (int i = CH; i >= 1; i--) begin
      k = (int'(ptr) + i) % CH;
      if (req[SEL_W'(k)]) begin
        gnt_idx = SEL_W'(k);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mux_nto1_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_nto1_arb                                                 |
// | Description : CH-to-1 data selector with valid/ready handshake and one     |
// |               output register stage. Channel chosen by select_i (fixed)    |
// |               or by round-robin arbitration (mode_i=1).                    |
// | Ports       : clk_i, rst_i (async, active-low)                             |
// |               mode_i, select_i          channel selection control          |
// |               data_i, valid_i, ready_o  CH producer channels               |
// |               data_o, valid_o, ready_i  consumer side (registered)         |
// |               grant_o                   channel of the beat in data_o      |
// |               last_i, last_o            only with MUX_LAST_EN defined      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mux_nto1_arb
  import mux_nto1_arb_pkg::*;
#(
  parameter  int size  = 32,
  parameter  int CH    = 4,
  localparam int SEL_W = $clog2(CH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mode_i,
  input  logic [SEL_W-1:0]     select_i,
  input  logic [CH*size-1:0]   data_i,
  input  logic [CH-1:0]        valid_i,
  output logic [CH-1:0]        ready_o,
  output logic [size-1:0]      data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
`ifdef MUX_LAST_EN
  input  logic [CH-1:0]        last_i,
  output logic                 last_o,
`endif
  output logic [SEL_W-1:0]     grant_o
);

  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] r_grant;
  logic [size-1:0]  r_data;
  logic             r_valid;

  logic [SEL_W-1:0] w_rr_idx;
  logic             w_rr_vld;
  logic [SEL_W-1:0] w_cand;
  logic             w_cand_vld;
  logic             w_can_load;
  logic [size-1:0]  w_sel_data;
  logic             w_sel_valid;
  logic             w_xfer;

`ifdef MUX_LAST_EN
  logic             r_lock;
  logic [SEL_W-1:0] r_lock_ch;
  logic             r_last;
  logic             w_sel_last;
`endif

  assign w_can_load = ~r_valid | ready_i;

  rr_arbiter #(.CH(CH)) u_rr_arbiter (
    .req     (valid_i),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_rr_idx),
    .gnt_vld (w_rr_vld)
  );

  // Candidate channel. An open packet overrides both selection modes.
  always_comb begin
    w_cand     = '0;
    w_cand_vld = 1'b0;
`ifdef MUX_LAST_EN
    if (r_lock) begin
      w_cand     = r_lock_ch;
      w_cand_vld = 1'b1;
    end else
`endif
    if (mode_i == MODE_RR) begin
      w_cand     = w_rr_idx;
      w_cand_vld = w_rr_vld;
    end else begin
      w_cand     = select_i;
      // An out-of-range select_i (only possible when CH is not a power of
      // two) selects nothing.
      w_cand_vld = (int'(select_i) < CH);
    end
  end

  // One-hot ready decode and channel data mux; compares against every legal
  // index so an out-of-range candidate can never slice beyond data_i.
  always_comb begin
    ready_o     = '0;
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
`ifdef MUX_LAST_EN
    w_sel_last  = 1'b1;
`endif
    for (int k = 0; k < CH; k++) begin
      if (w_cand_vld && (w_cand == SEL_W'(k))) begin
        ready_o[k]  = w_can_load;
        w_sel_data  = data_i[k*size +: size];
        w_sel_valid = valid_i[k];
`ifdef MUX_LAST_EN
        w_sel_last  = last_i[k];
`endif
      end
    end
  end

  assign w_xfer = w_cand_vld & w_can_load & w_sel_valid;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_grant  <= '0;
      // Park on the last channel so channel 0 wins the first arbitration.
      r_rr_ptr <= SEL_W'(CH - 1);
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_sel_data;
      r_grant <= w_cand;
      if (mode_i == MODE_RR) begin
        r_rr_ptr <= w_cand;
      end
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

`ifdef MUX_LAST_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
      r_last    <= 1'b0;
    end else if (w_xfer) begin
      r_lock    <= ~w_sel_last;
      r_lock_ch <= w_cand;
      r_last    <= w_sel_last;
    end
  end

  assign last_o = r_last;
`endif

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign grant_o = r_grant;

endmodule : mux_nto1_arb
`default_nettype wire

// File: tb/tb_mux_nto1_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mux_nto1_arb                                              |
// | Description : Self-checking bench for mux_nto1_arb. A CH=4 instance is     |
// |               driven by directed steps then random traffic and compared    |
// |               to a behavioural model; a CH=3 instance checks the           |
// |               out-of-range select case. Covers MUX_LAST_EN when defined.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mux_nto1_arb;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int N3 = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [1:0]     sel;
  logic [N*W-1:0] data_bus;
  logic [N-1:0]   vld;
  logic [N-1:0]   rdy_o;
  logic [W-1:0]   dout;
  logic           vout;
  logic           rdy_i;
  logic [1:0]     gnt;
  logic [N-1:0]   last_bus;
  logic           last_out;

  logic [N3*W-1:0] data3;
  logic [N3-1:0]   rdy3;
  logic [W-1:0]    dout3;
  logic            vout3;
  logic [1:0]      gnt3;
  logic            last3_out;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural reference state
  logic        m_valid;
  logic [31:0] m_data;
  int          m_grant;
  int          m_ptr;
  logic        m_lock;
  int          m_lock_ch;
  logic        m_last;

  always #5 clk = ~clk;

  mux_nto1_arb #(.size(W), .CH(N)) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .mode_i   (mode),
    .select_i (sel),
    .data_i   (data_bus),
    .valid_i  (vld),
    .ready_o  (rdy_o),
    .data_o   (dout),
    .valid_o  (vout),
    .ready_i  (rdy_i),
`ifdef MUX_LAST_EN
    .last_i   (last_bus),
    .last_o   (last_out),
`endif
    .grant_o  (gnt)
  );

  mux_nto1_arb #(.size(W), .CH(N3)) dut3 (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .mode_i   (1'b0),
    .select_i (2'd3),
    .data_i   (data3),
    .valid_i  (3'b111),
    .ready_o  (rdy3),
    .data_o   (dout3),
    .valid_o  (vout3),
    .ready_i  (1'b1),
`ifdef MUX_LAST_EN
    .last_i   (3'b111),
    .last_o   (last3_out),
`endif
    .grant_o  (gnt3)
  );

`ifndef MUX_LAST_EN
  assign last_out  = 1'b0;
  assign last3_out = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_grant = 0; m_ptr = N - 1;
    m_lock = 1'b0; m_lock_ch = 0; m_last = 1'b0;
  endtask

  // Channel the rules select this cycle, or -1 for none.
  function automatic int cand();
    if (m_lock) return m_lock_ch;
    if (mode == 1'b0) return (int'(sel) < N) ? int'(sel) : -1;
    for (int i = 1; i <= N; i++)
      if (vld[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  task automatic model_edge(input int c);
    logic lb;
    if (c >= 0 && (!m_valid || rdy_i) && vld[c]) begin
      m_valid = 1'b1;
      m_data  = data_bus[c*W +: W];
      m_grant = c;
      if (mode) m_ptr = c;
`ifdef MUX_LAST_EN
      lb = last_bus[c];
`else
      lb = 1'b1;
`endif
      m_lock    = !lb;
      m_lock_ch = c;
      m_last    = lb;
    end else if (rdy_i) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: check combinational ready, clock, check registered outputs.
  task automatic cycle();
    int c;
    logic [N-1:0] er;
    #1;
    c  = cand();
    er = (c >= 0 && (!m_valid || rdy_i)) ? N'(1 << c) : '0;
    chk("ready_o", 32'(rdy_o), 32'(er));
    chk("ch3_ready_o", 32'(rdy3), 32'd0);
    @(posedge clk);
    model_edge(c);
    #1;
    chk("valid_o", 32'(vout), 32'(m_valid));
    chk("data_o", dout, m_data);
    chk("grant_o", 32'(gnt), 32'(m_grant));
    chk("ch3_valid_o", 32'(vout3), 32'd0);
`ifdef MUX_LAST_EN
    chk("last_o", 32'(last_out), 32'(m_last));
`endif
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; data_bus = '0; vld = '0;
    rdy_i = 1'b0; last_bus = '1; data3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_valid_o", 32'(vout), 32'd0);
    chk("rst_data_o", dout, 32'd0);
    chk("rst_grant_o", 32'(gnt), 32'd0);

    // 1: fixed mode, select channel 2
    for (int k = 0; k < N; k++) data_bus[k*W +: W] = 32'hA5A5_0000 + k;
    mode = 1'b0; sel = 2'd2; vld = 4'b0100; rdy_i = 1'b1;
    #1 chk("t1_ready_o", 32'(rdy_o), 32'h4);
    cycle();
    chk("t1_data_o", dout, 32'hA5A5_0002);
    chk("t1_grant_o", 32'(gnt), 32'd2);

    // 2: round-robin rotation over all channels
    mode = 1'b1; vld = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t2_grant_seq", 32'(gnt), 32'(i % N));
    end

    // 3: back-pressure holds the beat; rotation resumes afterwards
    vld = 4'b1010;
    cycle();
    chk("t3_first_grant", 32'(gnt), 32'd1);
    rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_hold_grant", 32'(gnt), 32'd1);
      chk("t3_hold_ready", 32'(rdy_o), 32'd0);
    end
    rdy_i = 1'b1;
    cycle();
    chk("t3_next_grant", 32'(gnt), 32'd3);

    // 5: asynchronous reset while a beat is held under back-pressure
    rdy_i = 1'b0;
    cycle();
    rst_n = 1'b0;
    #1;
    chk("t5_valid_o", 32'(vout), 32'd0);
    chk("t5_data_o", dout, 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    vld = 4'b1111; rdy_i = 1'b1;
    cycle();
    chk("t5_first_grant", 32'(gnt), 32'd0);

`ifdef MUX_LAST_EN
    // 6: a three-beat packet on channel 1 locks the arbiter
    vld = 4'b0011;
    last_bus = 4'b1101; cycle(); chk("t6_grant_b0", 32'(gnt), 32'd1); chk("t6_last_b0", 32'(last_out), 32'd0);
    cycle(); chk("t6_grant_b1", 32'(gnt), 32'd1); chk("t6_last_b1", 32'(last_out), 32'd0);
    last_bus = 4'b1111; cycle(); chk("t6_grant_b2", 32'(gnt), 32'd1); chk("t6_last_b2", 32'(last_out), 32'd1);
    cycle(); chk("t6_grant_after", 32'(gnt), 32'd0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel   = 2'($urandom_range(0, 3));
      vld   = 4'($urandom);
      rdy_i = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) data_bus[k*W +: W] = $urandom;
      last_bus = 4'($urandom) | 4'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_mux_nto1_arb
`default_nettype wire
